// File: rtl/r512x16_stream_reader.sv
// Sequential read master for the r512x16 RAM: issues RA/RClk_En for a (StartAddr, Len)
// command and delivers the read words as a valid/ready stream with backpressure.
module r512x16_stream_reader #(
  parameter int addr_int       = 9,
  parameter int data_depth_int = 512,
  parameter int data_width_int = 16,
  parameter int buf_depth_int  = 4
) (
  input  logic                      RClk,
  input  logic                      Rst,
  input  logic                      Start,
  input  logic [addr_int-1:0]       StartAddr,
  input  logic [addr_int:0]         Len,
  input  logic                      Abort,
  output logic                      Busy,
  output logic                      Done,
  output logic [addr_int-1:0]       RA,
  output logic                      RClk_En,
  input  logic [data_width_int-1:0] RD,
  output logic [data_width_int-1:0] DOut,
  output logic                      DValid,
  input  logic                      DReady,
  output logic                      DLast
);

  localparam int LenW = addr_int + 1;
  localparam int PtrW = (buf_depth_int > 1) ? $clog2(buf_depth_int) : 1;
  localparam int CntW = $clog2(buf_depth_int + 1);
  localparam int OccW = $clog2(buf_depth_int + 3);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e                    state_q;
  logic [addr_int-1:0]       addr_q;
  logic [addr_int-1:0]       ra_q;
  logic                      rclkEn_q;
  logic                      rdValid_q;
  logic                      done_q;
  logic [LenW-1:0]           issueRem_q;
  logic [LenW-1:0]           acceptRem_q;
  logic [data_width_int-1:0] buf_q [buf_depth_int];
  logic [PtrW-1:0]           head_q;
  logic [PtrW-1:0]           tail_q;
  logic [CntW-1:0]           count_q;

  logic            dValid;
  logic            pop;
  logic            lastPop;
  logic [OccW-1:0] occ;
  logic            issueOk;

  function automatic logic [addr_int-1:0] incAddr(input logic [addr_int-1:0] a);
    return (a == addr_int'(data_depth_int - 1)) ? '0 : a + addr_int'(1);
  endfunction

  function automatic logic [PtrW-1:0] incPtr(input logic [PtrW-1:0] p);
    return (p == PtrW'(buf_depth_int - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Words already issued or in the RAM stage hold a reserved buffer slot, so an
  // issue is only allowed when every in-flight word is guaranteed a place.
  always_comb begin
    dValid  = (count_q != '0);
    pop     = dValid & DReady;
    lastPop = pop & (acceptRem_q == LenW'(1));
    occ     = OccW'(count_q) + OccW'(rclkEn_q) + OccW'(rdValid_q) - OccW'(pop);
    issueOk = (occ < OccW'(buf_depth_int));
  end

  always_ff @(posedge RClk or posedge Rst) begin
    if (Rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      ra_q        <= '0;
      rclkEn_q    <= 1'b0;
      rdValid_q   <= 1'b0;
      done_q      <= 1'b0;
      issueRem_q  <= '0;
      acceptRem_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      for (int i = 0; i < buf_depth_int; i++) buf_q[i] <= '0;
    end else if (Abort) begin
      state_q     <= IDLE;
      rclkEn_q    <= 1'b0;
      rdValid_q   <= 1'b0;
      done_q      <= 1'b0;
      issueRem_q  <= '0;
      acceptRem_q <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      done_q    <= lastPop;
      rdValid_q <= rclkEn_q;
      rclkEn_q  <= 1'b0;
      if (rdValid_q) begin
        buf_q[tail_q] <= RD;
        tail_q        <= incPtr(tail_q);
      end
      if (pop) begin
        head_q      <= incPtr(head_q);
        acceptRem_q <= acceptRem_q - LenW'(1);
      end
      count_q <= count_q + CntW'(rdValid_q) - CntW'(pop);

      // The first address goes out on the same edge that accepts the command.
      case (state_q)
        IDLE: begin
          if (Start) begin
            if (Len == '0) begin
              done_q <= 1'b1;
            end else begin
              acceptRem_q <= Len;
              state_q     <= RUN;
              if (issueOk) begin
                ra_q       <= StartAddr;
                rclkEn_q   <= 1'b1;
                addr_q     <= incAddr(StartAddr);
                issueRem_q <= Len - LenW'(1);
                if (Len == LenW'(1)) state_q <= DRAIN;
              end else begin
                addr_q     <= StartAddr;
                issueRem_q <= Len;
              end
            end
          end
        end
        RUN: begin
          if (issueOk) begin
            ra_q       <= addr_q;
            rclkEn_q   <= 1'b1;
            addr_q     <= incAddr(addr_q);
            issueRem_q <= issueRem_q - LenW'(1);
            if (issueRem_q == LenW'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (lastPop) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy    = (state_q != IDLE);
  assign Done    = done_q;
  assign RA      = ra_q;
  assign RClk_En = rclkEn_q;
  assign DOut    = buf_q[head_q];
  assign DValid  = dValid;
  assign DLast   = dValid & (acceptRem_q == LenW'(1));

endmodule

// File: tb/tb_r512x16_stream_reader.sv
// Scoreboard bench for r512x16_stream_reader: a RAM model feeds RD, commands push
// expected words into a queue, and a negedge monitor pops and compares.
module tb_r512x16_stream_reader;

  localparam int BufDepth = 4;

  logic        RClk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [8:0]  StartAddr;
  logic [9:0]  Len;
  logic        Abort;
  logic        Busy;
  logic        Done;
  logic [8:0]  RA;
  logic        RClk_En;
  logic [15:0] RD;
  logic [15:0] DOut;
  logic        DValid;
  logic        DReady;
  logic        DLast;

  r512x16_stream_reader #(
    .addr_int(9), .data_depth_int(512), .data_width_int(16), .buf_depth_int(BufDepth)
  ) dut (
    .RClk(RClk), .Rst(Rst), .Start(Start), .StartAddr(StartAddr), .Len(Len),
    .Abort(Abort), .Busy(Busy), .Done(Done), .RA(RA), .RClk_En(RClk_En), .RD(RD),
    .DOut(DOut), .DValid(DValid), .DReady(DReady), .DLast(DLast)
  );

  always #5 RClk = ~RClk;

  logic [15:0] mem [512];

  // RAM read port: registered data, garbage whenever no read was issued
  always @(posedge RClk) begin
    if (RClk_En) RD <= mem[RA];
    else         RD <= 16'($urandom);
  end

  int assertions = 0;
  int failures   = 0;
  int readyMode  = 0;
  bit fullRate   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer ready pattern: 0 always ready, 1 toggling, 2 random, 3 held low
  always @(posedge RClk) begin
    #1;
    case (readyMode)
      0:       DReady = 1'b1;
      1:       DReady = (DReady === 1'b1) ? 1'b0 : 1'b1;
      2:       DReady = 1'($urandom_range(0, 1));
      default: DReady = 1'b0;
    endcase
  end

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  exp_t        expQ[$];
  bit          modelBusy = 0;
  bit          expDone   = 0;
  bit          prevStall = 0;
  logic [15:0] prevDOut;
  logic        prevDLast;
  logic [8:0]  nextAddr;
  int          cmdLen, issuedCnt, acceptedCnt;
  int          cycle = 0, startCycle, lastXferCycle, wordIdx;
  bit          firstSeen;

  // Monitor/reference model: a command of Len words from StartAddr is the word
  // sequence mem[(StartAddr+i) mod 512], the last one flagged.
  always @(negedge RClk) begin
    bit   busyBefore, expDoneNext, newStall;
    exp_t e;
    cycle++;
    if (Rst) begin
      expQ.delete();
      modelBusy = 0;
      expDone   = 0;
      prevStall = 0;
    end else begin
      busyBefore = modelBusy;
      checkOutput("busy", 32'(Busy), 32'(busyBefore));
      checkOutput("done", 32'(Done), 32'(expDone));
      if (!busyBefore) begin
        checkOutput("idle_dvalid", 32'(DValid), 32'(0));
        checkOutput("idle_rclken", 32'(RClk_En), 32'(0));
        checkOutput("idle_dlast", 32'(DLast), 32'(0));
      end else if (RClk_En) begin
        checkOutput("ra", 32'(RA), 32'(nextAddr));
        checkOutput("issue_within_len", 32'(issuedCnt < cmdLen), 32'(1));
        checkOutput("outstanding_limit", 32'((issuedCnt + 1 - acceptedCnt) <= BufDepth), 32'(1));
        nextAddr = (nextAddr == 9'd511) ? 9'd0 : nextAddr + 9'd1;
        issuedCnt++;
      end
      if (prevStall) begin
        checkOutput("stall_dvalid", 32'(DValid), 32'(1));
        checkOutput("stall_dout", 32'(DOut), 32'(prevDOut));
        checkOutput("stall_dlast", 32'(DLast), 32'(prevDLast));
      end
      if (busyBefore && !firstSeen && DValid) begin
        checkOutput("first_latency", 32'(cycle - startCycle), 32'(3));
        firstSeen = 1;
      end
      expDoneNext = 0;
      newStall    = 0;
      if (Abort) begin
        expQ.delete();
        modelBusy = 0;
      end else begin
        if (DValid && DReady) begin
          if (expQ.size() == 0) begin
            checkOutput("xfer_expected_queue", 32'(expQ.size()), 32'(1));
          end else begin
            e = expQ.pop_front();
            checkOutput("dout", 32'(DOut), 32'(e.data));
            checkOutput("dlast", 32'(DLast), 32'(e.last));
            if (fullRate && wordIdx > 0)
              checkOutput("no_bubble", 32'(cycle - lastXferCycle), 32'(1));
            lastXferCycle = cycle;
            wordIdx++;
            acceptedCnt++;
            if (e.last) begin
              modelBusy   = 0;
              expDoneNext = 1;
            end
          end
        end
        newStall = DValid && !DReady;
        if (Start && !busyBefore) begin
          if (Len == 10'd0) begin
            expDoneNext = 1;
          end else begin
            modelBusy = 1;
            cmdLen    = int'(Len);
            for (int i = 0; i < cmdLen; i++) begin
              e.data = mem[(int'(StartAddr) + i) % 512];
              e.last = (i == cmdLen - 1);
              expQ.push_back(e);
            end
            nextAddr    = StartAddr;
            issuedCnt   = 0;
            acceptedCnt = 0;
            startCycle  = cycle;
            firstSeen   = 0;
            wordIdx     = 0;
          end
        end
      end
      expDone   = expDoneNext;
      prevStall = newStall;
      prevDOut  = DOut;
      prevDLast = DLast;
    end
  end

  task automatic applyStimulus(input logic [8:0] addr, input logic [9:0] len);
    @(posedge RClk);
    #1;
    Start     = 1'b1;
    StartAddr = addr;
    Len       = len;
    @(posedge RClk);
    #1;
    Start = 1'b0;
  endtask

  task automatic waitIdle(input int maxCycles);
    int n = 0;
    while (modelBusy && n < maxCycles) begin
      @(posedge RClk);
      n++;
    end
    if (modelBusy) checkOutput("waitIdle_timeout", 32'(modelBusy), 32'(0));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(Busy), 32'(0));
    checkOutput({tag, "_done"}, 32'(Done), 32'(0));
    checkOutput({tag, "_ra"}, 32'(RA), 32'(0));
    checkOutput({tag, "_rclken"}, 32'(RClk_En), 32'(0));
    checkOutput({tag, "_dout"}, 32'(DOut), 32'(0));
    checkOutput({tag, "_dvalid"}, 32'(DValid), 32'(0));
    checkOutput({tag, "_dlast"}, 32'(DLast), 32'(0));
  endtask

  initial begin
    Rst = 1'b1; Start = 1'b0; StartAddr = '0; Len = '0; Abort = 1'b0;
    for (int i = 0; i < 512; i++) mem[i] = 16'h1000 + 16'(i);
    #1;
    checkResetOutputs("reset");
    repeat (2) @(posedge RClk);
    #1 Rst = 1'b0;

    $display("[TB] basic full-rate read and address wrap");
    fullRate = 1;
    applyStimulus(9'd5, 10'd4);
    waitIdle(50);
    applyStimulus(9'd510, 10'd4);
    waitIdle(50);
    fullRate = 0;

    $display("[TB] backpressure: toggling then held low");
    readyMode = 1;
    applyStimulus(9'd100, 10'd16);
    repeat (8) @(posedge RClk);
    readyMode = 3;
    repeat (10) @(posedge RClk);
    readyMode = 0;
    waitIdle(100);

    $display("[TB] zero-length command");
    applyStimulus(9'd7, 10'd0);
    repeat (4) @(posedge RClk);

    $display("[TB] abort mid-command then restart");
    applyStimulus(9'd20, 10'd64);
    repeat (11) @(posedge RClk);
    readyMode = 3;
    @(posedge RClk);
    #1 Abort = 1'b1;
    @(posedge RClk);
    #1 Abort = 1'b0;
    readyMode = 0;
    repeat (3) @(posedge RClk);
    applyStimulus(9'd300, 10'd2);
    waitIdle(50);

    $display("[TB] length beyond depth wraps");
    readyMode = 2;
    applyStimulus(9'd0, 10'd600);
    waitIdle(3000);

    $display("[TB] start while busy, then reset mid-stream");
    applyStimulus(9'd40, 10'd16);
    repeat (3) @(posedge RClk);
    applyStimulus(9'd200, 10'd3);
    repeat (3) @(posedge RClk);
    #2 Rst = 1'b1;
    #1;
    checkResetOutputs("midreset");
    repeat (2) @(posedge RClk);
    #1 Rst = 1'b0;
    readyMode = 0;

    $display("[TB] randomized commands");
    for (int k = 0; k < 20; k++) begin
      int len;
      for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
      len       = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
      readyMode = ($urandom_range(0, 1) == 0) ? 0 : 2;
      fullRate  = (readyMode == 0);
      applyStimulus(9'($urandom_range(0, 511)), 10'(len));
      waitIdle(400);
      fullRate = 0;
    end
    repeat (3) @(posedge RClk);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
